// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port memory access controller arbitrating fetch, load and store
// One access per two cycles: IDLE samples a request, ISSUE drives memory, the result lands on return to IDLE.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_func3,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [2:0]  mem_func3,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_data_out,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        store_done,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FAULT} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  state_t r_state, w_next;
  kind_t  r_kind, w_kind;
  logic   w_accept;
  logic   w_is_data, w_f3_ok, w_align_ok, w_data_ok, w_fetch_ok;

  always_comb begin
    w_is_data  = ex_mem_read | ex_mem_write;
    // a simultaneous read+write is a store, so store legality applies
    if (ex_mem_write)
      w_f3_ok = (ex_func3 == 3'b000) || (ex_func3 == 3'b001) || (ex_func3 == 3'b010);
    else
      w_f3_ok = (ex_func3 == 3'b000) || (ex_func3 == 3'b001) || (ex_func3 == 3'b010) ||
                (ex_func3 == 3'b100) || (ex_func3 == 3'b101);
    w_align_ok = 1'b1;
    if (ex_func3 == 3'b010)
      w_align_ok = (ex_addr[1:0] == 2'b00);
    else if ((ex_func3 == 3'b001) || (ex_func3 == 3'b101))
      w_align_ok = ~ex_addr[0];
    w_data_ok  = (ex_addr[31:7] == 25'd0) && w_f3_ok && w_align_ok;
    w_fetch_ok = (if_pc[31:7] == 25'd0) && (if_pc[1:0] == 2'b00);
  end

  always_comb begin
    w_next   = r_state;
    w_kind   = K_FETCH;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_data) begin
          if (w_data_ok) begin
            w_next   = S_ISSUE;
            w_kind   = ex_mem_write ? K_STORE : K_LOAD;
            w_accept = 1'b1;
          end else begin
            w_next = S_FAULT;
          end
        end else if (if_req) begin
          if (w_fetch_ok) begin
            w_next   = S_ISSUE;
            w_kind   = K_FETCH;
            w_accept = 1'b1;
          end else begin
            w_next = S_FAULT;
          end
        end
      end
      S_ISSUE: w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // The memory-side outputs double as the latched request for the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind      <= K_FETCH;
      mem_addr    <= 14'd0;
      mem_data_in <= 32'd0;
      mem_func3   <= 3'd0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      inst_out    <= 32'd0;
      inst_valid  <= 1'b0;
      load_data   <= 32'd0;
      load_valid  <= 1'b0;
      store_done  <= 1'b0;
    end else begin
      mem_addr    <= 14'd0;
      mem_data_in <= 32'd0;
      mem_func3   <= 3'd0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      inst_valid  <= 1'b0;
      load_valid  <= 1'b0;
      store_done  <= 1'b0;
      if (w_accept) begin
        r_kind <= w_kind;
        case (w_kind)
          K_LOAD: begin
            MemRead   <= 1'b1;
            mem_addr  <= {ex_addr[6:0], 7'd0};
            mem_func3 <= ex_func3;
          end
          K_STORE: begin
            MemWrite    <= 1'b1;
            mem_addr    <= {ex_addr[6:0], 7'd0};
            mem_func3   <= ex_func3;
            mem_data_in <= ex_wdata;
          end
          default: begin
            mem_addr  <= {7'd0, if_pc[6:0]};
            mem_func3 <= 3'b010;
          end
        endcase
      end
      if (r_state == S_ISSUE) begin
        case (r_kind)
          K_LOAD: begin
            load_data  <= mem_data_out;
            load_valid <= 1'b1;
          end
          K_STORE: store_done <= 1'b1;
          default: begin
            inst_out   <= mem_data_out;
            inst_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign fault = (r_state == S_FAULT);
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed and randomized bench for mem_access_ctrl with a byte-level memory model
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [2:0]  ex_func3 = 3'd0;
  logic [13:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [2:0]  mem_func3;
  logic        MemRead, MemWrite;
  logic [31:0] mem_data_out;
  logic [31:0] inst_out, load_data;
  logic        inst_valid, load_valid, store_done, fault, busy;

  int n_checks = 0;
  int n_err = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_pc(if_pc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_func3(ex_func3), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_func3(mem_func3), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_data_out(mem_data_out), .inst_out(inst_out),
    .inst_valid(inst_valid), .load_data(load_data), .load_valid(load_valid),
    .store_done(store_done), .fault(fault), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // instruction memory contents are a fixed function of the byte offset
  function automatic logic [31:0] iw(input logic [6:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0107);
  endfunction

  function automatic logic [31:0] fmt(input logic [7:0] b [128], input logic [6:0] o, input logic [2:0] f);
    logic [31:0] w;
    w = {b[o + 7'd3], b[o + 7'd2], b[o + 7'd1], b[o]};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return (f[1:0] == 2'd2) ? 4 : (f[1:0] == 2'd1) ? 2 : 1;
  endfunction

  // memory stub driven by the DUT's memory port
  logic [7:0] s_mem [128];
  always_comb mem_data_out = MemRead ? fmt(s_mem, mem_addr[13:7], mem_func3) : iw(mem_addr[6:0]);
  always @(posedge clk) begin
    if (!rst && MemWrite)
      for (int k = 0; k < nbytes(mem_func3); k++)
        s_mem[mem_addr[13:7] + 7'(k)] = mem_data_in[8*k +: 8];
  end

  // reference model: request-level view of what each cycle must show
  localparam int P_NONE = 0, P_FETCH = 1, P_LOAD = 2, P_STORE = 3, P_FAULT = 4;
  logic [7:0]  m_mem [128];
  int          p_kind = P_NONE;
  logic [6:0]  p_off = '0;
  logic [2:0]  p_f3 = '0;
  logic [31:0] p_wd = '0;
  logic [13:0] e_mem_addr = '0;
  logic [31:0] e_mem_data_in = '0, e_inst_out = '0, e_load_data = '0;
  logic [2:0]  e_mem_func3 = '0;
  logic        e_MemRead = 0, e_MemWrite = 0, e_inst_valid = 0, e_load_valid = 0;
  logic        e_store_done = 0, e_fault = 0, e_busy = 0;

  always @(posedge clk or posedge rst) begin
    bit bad, st;
    e_mem_addr = '0; e_mem_data_in = '0; e_mem_func3 = '0;
    e_MemRead = 0; e_MemWrite = 0; e_inst_valid = 0; e_load_valid = 0;
    e_store_done = 0; e_fault = 0; e_busy = 0;
    if (rst) begin
      p_kind = P_NONE; e_inst_out = '0; e_load_data = '0;
    end else if (p_kind != P_NONE) begin
      if (p_kind == P_FETCH) begin e_inst_out = iw(p_off); e_inst_valid = 1; end
      if (p_kind == P_LOAD)  begin e_load_data = fmt(m_mem, p_off, p_f3); e_load_valid = 1; end
      if (p_kind == P_STORE) begin
        for (int k = 0; k < nbytes(p_f3); k++) m_mem[p_off + 7'(k)] = p_wd[8*k +: 8];
        e_store_done = 1;
      end
      p_kind = P_NONE;
    end else if (ex_mem_read || ex_mem_write) begin
      st  = ex_mem_write;
      bad = (ex_addr > 32'd127);
      if (st) bad |= !(ex_func3 inside {3'd0, 3'd1, 3'd2});
      else    bad |= !(ex_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!bad) bad = (ex_addr % nbytes(ex_func3)) != 0;
      e_busy = 1;
      if (bad) begin
        p_kind = P_FAULT; e_fault = 1;
      end else begin
        p_kind = st ? P_STORE : P_LOAD;
        p_off = ex_addr[6:0]; p_f3 = ex_func3; p_wd = ex_wdata;
        e_mem_addr = 14'(ex_addr) * 14'd128;
        e_mem_func3 = ex_func3;
        if (st) begin e_MemWrite = 1; e_mem_data_in = ex_wdata; end
        else e_MemRead = 1;
      end
    end else if (if_req) begin
      e_busy = 1;
      if (if_pc > 32'd127 || (if_pc % 4) != 0) begin
        p_kind = P_FAULT; e_fault = 1;
      end else begin
        p_kind = P_FETCH; p_off = if_pc[6:0];
        e_mem_addr = 14'(if_pc); e_mem_func3 = 3'b010;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
      chk("mem_data_in", mem_data_in, e_mem_data_in);
      chk("mem_func3", 32'(mem_func3), 32'(e_mem_func3));
      chk("MemRead", 32'(MemRead), 32'(e_MemRead));
      chk("MemWrite", 32'(MemWrite), 32'(e_MemWrite));
      chk("inst_out", inst_out, e_inst_out);
      chk("inst_valid", 32'(inst_valid), 32'(e_inst_valid));
      chk("load_data", load_data, e_load_data);
      chk("load_valid", 32'(load_valid), 32'(e_load_valid));
      chk("store_done", 32'(store_done), 32'(e_store_done));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic setreq(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic ir, input logic [31:0] pc);
    ex_mem_read = rd; ex_mem_write = wr; ex_addr = a; ex_wdata = wd;
    ex_func3 = f3; if_req = ir; if_pc = pc;
  endtask

  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [31:0] a, wd, pc;
    logic [2:0]  f3;
    int op;
    for (int i = 0; i < 128; i++) begin
      s_mem[i] = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_MemWrite", 32'(MemWrite), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_fault", 32'(fault), 0);
    #1 rst = 1'b0;

    setreq(0, 1, 32'h08, 32'hDEADBEEF, 3'b010, 0, 0);
    @(negedge clk);
    chk("sw_MemWrite", 32'(MemWrite), 1);
    chk("sw_mem_addr", 32'(mem_addr), 32'h0400);
    chk("sw_wdata", mem_data_in, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_done", 32'(store_done), 1);
    setreq(1, 0, 32'h08, 0, 3'b010, 0, 0);
    @(negedge clk);
    chk("lw_MemRead", 32'(MemRead), 1);
    @(negedge clk);
    chk("lw_valid", 32'(load_valid), 1);
    chk("lw_data", load_data, 32'hDEADBEEF);

    setreq(1, 0, 32'h00, 0, 3'b010, 1, 32'h04);
    @(negedge clk);
    chk("cont_MemRead", 32'(MemRead), 1);
    chk("cont_busy", 32'(busy), 1);
    @(negedge clk);
    chk("cont_lvalid", 32'(load_valid), 1);
    ex_mem_read = 1'b0;
    @(negedge clk);
    chk("cont_fetch_addr", 32'(mem_addr), 32'h0004);
    @(negedge clk);
    chk("cont_ivalid", 32'(inst_valid), 1);
    chk("cont_inst", inst_out, 32'hC4DA041C);

    setreq(1, 0, 32'h02, 0, 3'b010, 0, 0);
    @(negedge clk); chk("lw2_fault", 32'(fault), 1); @(negedge clk);
    setreq(1, 0, 32'h01, 0, 3'b001, 0, 0);
    @(negedge clk); chk("lh1_fault", 32'(fault), 1); @(negedge clk);
    setreq(0, 0, 0, 0, 3'b000, 1, 32'h06);
    @(negedge clk); chk("pc6_fault", 32'(fault), 1); @(negedge clk);
    setreq(1, 0, 32'h80, 0, 3'b000, 0, 0);
    @(negedge clk); chk("lb80_fault", 32'(fault), 1); @(negedge clk);
    setreq(1, 0, 32'h7F, 0, 3'b000, 0, 0);
    @(negedge clk); chk("lb7f_addr", 32'(mem_addr), 32'h3F80);
    @(negedge clk); chk("lb7f_data", load_data, 32'h0000007C);

    for (int i = 0; i < 3; i++) begin
      setreq(0, 0, 0, 0, 3'b000, 1, 32'(i * 4));
      @(negedge clk);
      @(negedge clk);
      chk("b2b_ivalid", 32'(inst_valid), 1);
      if (i == 0) chk("b2b_inst0", inst_out, 32'hC0DE0000);
      if (i == 2) chk("b2b_inst8", inst_out, 32'hC8D60838);
    end

    setreq(0, 1, 32'h10, 32'h000000A5, 3'b000, 0, 0);
    @(negedge clk);
    chk("sb_MemWrite", 32'(MemWrite), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_MemWrite", 32'(MemWrite), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    setreq(0, 0, 0, 0, 3'b000, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    setreq(1, 0, 32'h10, 0, 3'b100, 0, 0);
    @(negedge clk);
    chk("post_rst_store_done", 32'(store_done), 0);
    @(negedge clk);
    chk("post_rst_lbu", load_data, 32'h00000073);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        setreq(0, 0, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
      end
      op = $urandom_range(0, 5);
      a  = $urandom_range(0, 127);
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) < 7) a = a & ~32'(nbytes(f3) - 1);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(7, 31));
      wd = $urandom;
      pc = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) pc = pc | 32'h100;
      case (op)
        0, 1: setreq(1, 0, a, wd, f3, $urandom_range(0, 3) == 0, pc);
        2:    setreq(0, 1, a, wd, f3, $urandom_range(0, 3) == 0, pc);
        3:    setreq(1, 1, a, wd, f3, $urandom_range(0, 3) == 0, pc);
        default: setreq(0, 0, a, wd, f3, 1, pc);
      endcase
      @(negedge clk);
      @(negedge clk);
    end

    setreq(0, 0, 0, 0, 3'b000, 0, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none; data window is 128 bytes (offset 0..127), instruction window is 128 bytes (offset 0..127).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  pipeline requests an instruction fetch.
REQ-005 if_pc  input  32  fetch byte address.
REQ-006 ex_mem_read  input  1  pipeline requests a data load.
REQ-007 ex_mem_write  input  1  pipeline requests a data store.
REQ-008 ex_addr  input  32  data byte address.
REQ-009 ex_wdata  input  32  store data.
REQ-010 ex_func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 mem_addr  output  14  to memory: [13:7] = data byte offset, [6:0] = instruction byte offset.
REQ-012 mem_data_in  output  32  store data to memory.
REQ-013 mem_func3  output  3  access size to memory.
REQ-014 MemRead  output  1  memory data-read enable.
REQ-015 MemWrite  output  1  memory write enable.
REQ-016 mem_data_out  input  32  read data from memory.
REQ-017 inst_out  output  32  fetched instruction; inst_valid  output  1  one-cycle qualifier.
REQ-018 load_data  output  32  load result; load_valid  output  1  one-cycle qualifier.
REQ-019 store_done  output  1  one-cycle store completion pulse; fault  output  1  one-cycle pulse for a rejected request; busy  output  1  high when state is not IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, FAULT; requests are sampled only in IDLE; the pipeline holds request inputs stable while busy=1.
REQ-021 In IDLE a data request (ex_mem_read|ex_mem_write) has priority over if_req; a deferred fetch is taken on the next IDLE cycle in which no data request is present.
REQ-022 ex_mem_read and ex_mem_write both high: treat as store; no read is performed.
REQ-023 Data request is rejected (IDLE->FAULT) when ex_addr[31:7]!=0, or W with ex_addr[1:0]!=0, or H/HU with ex_addr[0]!=0, or ex_func3 not in {000,001,010,100,101} for loads, or ex_func3 not in {000,001,010} for stores.
REQ-024 Fetch is rejected (IDLE->FAULT) when if_pc[31:7]!=0 or if_pc[1:0]!=0.
REQ-025 Accepted request: IDLE->ISSUE with the type (FETCH/LOAD/STORE), offset, func3 and wdata latched.
REQ-026 In ISSUE: mem_addr[13:7]=latched data offset for LOAD/STORE, mem_addr[6:0]=latched fetch offset for FETCH, the unused field is 0; MemRead=1 only for LOAD, MemWrite=1 only for STORE, each for exactly one cycle.
REQ-027 MemRead/MemWrite/mem_addr/mem_func3/mem_data_in are registered outputs; outside ISSUE all are 0.
REQ-028 At the edge ending ISSUE: LOAD captures mem_data_out into load_data and pulses load_valid; FETCH captures into inst_out and pulses inst_valid; STORE pulses store_done; state returns to IDLE.
REQ-029 Latency: request sampled at edge N, valid/done pulse high during cycle N+2; maximum throughput is one access per two cycles.
REQ-030 FAULT lasts one cycle with fault=1, no memory enable asserted, then IDLE.
REQ-031 load_data and inst_out hold their last captured value until the next capture of the same type.

Reset
REQ-032 rst=1 forces state IDLE immediately and clears every output (all data buses 0, all pulses 0, busy 0) regardless of clock.
REQ-033 Reset during ISSUE aborts the access: MemWrite drops asynchronously, no valid/done pulse follows, and the latched request is discarded.
REQ-034 First request is sampled on the first rising edge after rst deasserts.

Verification
REQ-035 Store then load: SW ex_addr=0x08, wdata=0xDEADBEEF -> MemWrite=1 one cycle with mem_addr=0x0400, store_done; then LW 0x08 -> load_valid, load_data=0xDEADBEEF.
REQ-036 Contention: if_req (pc=0x04) and LW 0x00 in the same IDLE cycle -> load serviced first, busy held; fetch issued next with mem_addr=0x0004, inst_valid two cycles later.
REQ-037 Misalignment: LW 0x02, LH 0x01, fetch pc=0x06 -> fault pulse each, MemRead/MemWrite never asserted.
REQ-038 Range: LB 0x80 -> fault; LB 0x7F -> accepted, mem_addr=0x3F80.
REQ-039 Reset mid-store: rst asserted during ISSUE of SB -> MemWrite 0 immediately, no store_done, busy 0.
REQ-040 Back-to-back fetches pc=0x00,0x04,0x08 -> inst_valid every second cycle with matching inst_out values.
